// File: rtl/bus_master_arbiter_if.sv
// Requester and bus signal bundle for bus_master_arbiter.
// The arbiter connects through the master modport; requesters and endpoints use the slave modport.
interface bus_master_arbiter_if #(
   parameter int NREQ       = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8
);
   logic [NREQ-1:0]            req;
   logic [NREQ-1:0]            req_r_wn;
   logic [NREQ*ADDR_WIDTH-1:0] req_addr;
   logic [NREQ*DATA_WIDTH-1:0] req_wdata;
   logic [NREQ-1:0]            gnt;
   logic [NREQ-1:0]            ack;
   logic [DATA_WIDTH-1:0]      ack_rdata;
   logic                       bus_r_wn;
   logic [ADDR_WIDTH-1:0]      bus_addr;
   logic [DATA_WIDTH-1:0]      bus_wdata;
   logic [DATA_WIDTH-1:0]      bus_rdata;
   logic                       busy;

   modport master (
      input  req, req_r_wn, req_addr, req_wdata, bus_rdata,
      output gnt, ack, ack_rdata, bus_r_wn, bus_addr, bus_wdata, busy
   );

   modport slave (
      output req, req_r_wn, req_addr, req_wdata, bus_rdata,
      input  gnt, ack, ack_rdata, bus_r_wn, bus_addr, bus_wdata, busy
   );
endinterface

// File: rtl/bus_master_arbiter.sv
// Round-robin arbiter sharing one parallel bus between NREQ requesters,
// with programmable setup / strobe / read-wait timing per transaction.
module bus_master_arbiter #(
   parameter int                    NREQ       = 4,
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 8,
   parameter int                    SETUP_CYC  = 1,
   parameter int                    STROBE_CYC = 1,
   parameter int                    READ_CYC   = 2,
   parameter logic [ADDR_WIDTH-1:0] PARK_ADDR  = '1
) (
   input logic                  clk,
   input logic                  rst_n,
   bus_master_arbiter_if.master bus
);
   localparam int MAX_AB = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
   localparam int MAXC   = (MAX_AB > READ_CYC) ? MAX_AB : READ_CYC;
   localparam int CW     = $clog2(MAXC + 1);
   localparam int IW     = $clog2(NREQ);

   localparam logic [CW-1:0] SETUP_LD  = CW'(SETUP_CYC - 1);
   localparam logic [CW-1:0] STROBE_LD = CW'(STROBE_CYC - 1);
   localparam logic [CW-1:0] READ_LD   = CW'(READ_CYC - 1);

   if (SETUP_CYC < 1 || STROBE_CYC < 1 || READ_CYC < 1 || NREQ < 2 || NREQ > 8) begin : g_bad_param
      $error("bus_master_arbiter: timing parameters must be >= 1 and NREQ in 2..8");
   end

   typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, READ, DONE} state_t;

   state_t                state_q, state_d;
   logic [IW-1:0]         idx_q, ptr_q, win_idx;
   logic                  win_found;
   logic                  rd_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q, rdata_q;
   logic [CW-1:0]         cnt_q;
   int unsigned           k;

   // First requester at or above the pointer, wrapping modulo NREQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      k         = 0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         k = (32'(ptr_q) + i) % NREQ;
         if (!win_found && bus.req[k]) begin
            win_found = 1'b1;
            win_idx   = IW'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (win_found) state_d = bus.req_r_wn[win_idx] ? READ : SETUP;
         SETUP:   if (cnt_q == '0) state_d = STROBE;
         STROBE:  if (cnt_q == '0) state_d = HOLD;
         HOLD:    state_d = DONE;
         READ:    if (cnt_q == '0) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q   <= '0;
         ptr_q   <= '0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            IDLE: if (win_found) begin
               idx_q   <= win_idx;
               rd_q    <= bus.req_r_wn[win_idx];
               addr_q  <= bus.req_addr[32'(win_idx)*ADDR_WIDTH +: ADDR_WIDTH];
               wdata_q <= bus.req_wdata[32'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
               cnt_q   <= bus.req_r_wn[win_idx] ? READ_LD : SETUP_LD;
            end
            SETUP:  cnt_q <= (cnt_q == '0) ? STROBE_LD : cnt_q - CW'(1);
            STROBE: if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
            READ: begin
               if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
               else             rdata_q <= bus.bus_rdata;
            end
            DONE:    ptr_q <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.bus_r_wn  = 1'b1;
      bus.bus_addr  = PARK_ADDR;
      bus.bus_wdata = '0;
      bus.gnt       = '0;
      bus.ack       = '0;
      bus.ack_rdata = '0;
      bus.busy      = (state_q != IDLE);
      unique case (state_q)
         SETUP, HOLD: begin
            bus.bus_addr  = addr_q;
            bus.bus_wdata = wdata_q;
         end
         STROBE: begin
            bus.bus_r_wn  = 1'b0;
            bus.bus_addr  = addr_q;
            bus.bus_wdata = wdata_q;
         end
         READ:    bus.bus_addr = addr_q;
         default: ;
      endcase
      if (state_q != IDLE) bus.gnt[idx_q] = 1'b1;
      if (state_q == DONE) begin
         bus.ack[idx_q] = 1'b1;
         if (rd_q) bus.ack_rdata = rdata_q;
      end
   end
endmodule
